// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider producing one quotient bit per clock.
// Start/Ready/Done handshake; divide-by-zero short-circuits straight to DONE.
module restoring_divider #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] Dividend,
   input  logic [WIDTH-1:0] Divisor,
   output logic             Ready,
   output logic             Done,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remainder,
   output logic             DivByZero
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t state, state_next;

   // The restored partial remainder is always below the divisor, so only
   // WIDTH bits need storing; the shifted trial value carries the extra bit.
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] div_q;
   logic [CW-1:0]    count;

   logic [WIDTH:0]   rem_shifted;
   logic [WIDTH:0]   trial;
   logic             no_borrow;
   logic [WIDTH-1:0] rem_step;
   logic [WIDTH-1:0] quo_step;
   logic             last_step;

   always_comb begin
      rem_shifted = {rem_q, quo_q[WIDTH-1]};
      trial       = rem_shifted - {1'b0, div_q};
      no_borrow   = ~trial[WIDTH];
      rem_step    = no_borrow ? trial[WIDTH-1:0] : rem_shifted[WIDTH-1:0];
      quo_step    = {quo_q[WIDTH-2:0], no_borrow};
      last_step   = (count == LAST_STEP);
   end

   always_comb begin
      state_next = state;
      Ready      = 1'b0;
      Done       = 1'b0;
      case (state)
         S_IDLE: begin
            Ready = 1'b1;
            if (Start) begin
               state_next = (Divisor == '0) ? S_DONE : S_CALC;
            end
         end
         S_CALC: begin
            if (last_step) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            Done       = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= S_IDLE;
         rem_q     <= '0;
         quo_q     <= '0;
         div_q     <= '0;
         count     <= '0;
         Quotient  <= '0;
         Remainder <= '0;
         DivByZero <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            S_IDLE: begin
               if (Start) begin
                  div_q     <= Divisor;
                  quo_q     <= Dividend;
                  rem_q     <= '0;
                  count     <= '0;
                  DivByZero <= 1'b0;
                  if (Divisor == '0) begin
                     Quotient  <= '1;
                     Remainder <= Dividend;
                     DivByZero <= 1'b1;
                  end
               end
            end
            S_CALC: begin
               rem_q <= rem_step;
               quo_q <= quo_step;
               count <= count + 1'b1;
               if (last_step) begin
                  Quotient  <= quo_step;
                  Remainder <= rem_step;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
